// File: rtl/pipelined_prefix_adder.sv
// rtl/pipelined_prefix_adder.sv - pipelined Sklansky parallel-prefix adder/subtractor with valid/ready flow control
module pipelined_prefix_adder #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] y,
  output logic             cout,
  output logic             ovf,
  output logic             zero
);

  localparam int LEVELS = $clog2(WIDTH);

  // Global stall: everything moves together only when the output slot can be freed.
  logic advance;
  assign advance  = !out_valid || out_ready;
  assign in_ready = advance && !reset;

  // Stage k holds the operands, carry-in and the group generate/propagate after k prefix levels.
  logic [LEVELS:0]  v_s;
  logic [LEVELS:0]  c_s;
  logic [WIDTH-1:0] a_s [0:LEVELS];
  logic [WIDTH-1:0] b_s [0:LEVELS];
  logic [WIDTH-1:0] g_s [0:LEVELS];
  logic [WIDTH-1:0] p_s [0:LEVELS-1];

  logic [WIDTH-1:0] g_nx [0:LEVELS-1];
  logic [WIDTH-1:0] p_nx [0:LEVELS-1];

  logic [WIDTH-1:0] b_eff;
  logic             c_in;
  logic [WIDTH-1:0] g_in;
  logic [WIDTH-1:0] p_in;

  // Bit-level generate/propagate; the carry-in is merged into bit 0's generate,
  // which is the cell directly above the carry-in position.
  always_comb begin
    b_eff   = sub ? ~b : b;
    c_in    = sub ? 1'b1 : cin;
    p_in    = a | b_eff;
    g_in    = a & b_eff;
    g_in[0] = g_in[0] | (p_in[0] & c_in);
  end

  // Sklansky levels: at level l, every bit whose index has bit l set absorbs the
  // group ending just below its 2^l-aligned half.
  always_comb begin
    for (int l = 0; l < LEVELS; l++) begin
      g_nx[l] = g_s[l];
      p_nx[l] = p_s[l];
      for (int i = 0; i < WIDTH; i++) begin
        if (((i >> l) & 1) == 1) begin
          g_nx[l][i] = g_s[l][i] | (p_s[l][i] & g_s[l][((i >> l) << l) - 1]);
          p_nx[l][i] = p_s[l][i] & p_s[l][((i >> l) << l) - 1];
        end
      end
    end
  end

  // Prefix pipeline registers; only valid bits need clearing on reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      v_s <= '0;
    end else if (advance) begin
      v_s[0] <= in_valid;
      c_s[0] <= c_in;
      a_s[0] <= a;
      b_s[0] <= b_eff;
      g_s[0] <= g_in;
      p_s[0] <= p_in;
      for (int k = 1; k <= LEVELS; k++) begin
        v_s[k] <= v_s[k-1];
        c_s[k] <= c_s[k-1];
        a_s[k] <= a_s[k-1];
        b_s[k] <= b_s[k-1];
        g_s[k] <= g_nx[k-1];
      end
      for (int k = 1; k < LEVELS; k++) begin
        p_s[k] <= p_nx[k-1];
      end
    end
  end

  logic [WIDTH-1:0] carries;
  logic [WIDTH-1:0] sum;
  logic             sum_cout;
  logic             sum_ovf;
  logic             sum_zero;

  // Carry into bit i is the group generate of bits i-1..0; bit 0 gets the raw carry-in.
  always_comb begin
    carries  = {g_s[LEVELS][WIDTH-2:0], c_s[LEVELS]};
    sum      = a_s[LEVELS] ^ b_s[LEVELS] ^ carries;
    sum_cout = g_s[LEVELS][WIDTH-1];
    sum_ovf  = (a_s[LEVELS][WIDTH-1] == b_s[LEVELS][WIDTH-1]) &&
               (sum[WIDTH-1] != a_s[LEVELS][WIDTH-1]);
    sum_zero = (sum == '0);
  end

  // Output stage; holds while stalled so the result stays stable until taken.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid <= 1'b0;
      y         <= '0;
      cout      <= 1'b0;
      ovf       <= 1'b0;
      zero      <= 1'b0;
    end else if (advance) begin
      out_valid <= v_s[LEVELS];
      y         <= sum;
      cout      <= sum_cout;
      ovf       <= sum_ovf;
      zero      <= sum_zero;
    end
  end

endmodule

// File: tb/tb_pipelined_prefix_adder.sv
// tb/tb_pipelined_prefix_adder.sv - scoreboard bench for pipelined_prefix_adder
module tb_pipelined_prefix_adder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        in_valid, in_ready, out_valid, out_ready;
  logic [31:0] a, b, y;
  logic        cin, sub, cout, ovf, zero;

  logic        in_valid8, in_ready8, out_valid8;
  logic [7:0]  a8, b8, y8;
  logic        cin8, sub8, cout8, ovf8, zero8;

  pipelined_prefix_adder #(.WIDTH(32)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin), .sub(sub), .out_valid(out_valid), .out_ready(out_ready),
    .y(y), .cout(cout), .ovf(ovf), .zero(zero)
  );

  pipelined_prefix_adder #(.WIDTH(8)) dut8 (
    .clk(clk), .reset(reset), .in_valid(in_valid8), .in_ready(in_ready8),
    .a(a8), .b(b8), .cin(cin8), .sub(sub8), .out_valid(out_valid8), .out_ready(1'b1),
    .y(y8), .cout(cout8), .ovf(ovf8), .zero(zero8)
  );

  typedef struct packed {
    logic [31:0] y;
    logic        cout;
    logic        ovf;
    logic        zero;
  } res_t;

  res_t q[$];
  int   checks = 0;
  int   errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic res_t model(input logic [31:0] a_i, input logic [31:0] b_i,
                                 input logic cin_i, input logic sub_i);
    res_t        r;
    logic [31:0] bb;
    logic [32:0] full;
    bb     = sub_i ? ~b_i : b_i;
    full   = {1'b0, a_i} + {1'b0, bb} + {32'd0, (sub_i ? 1'b1 : cin_i)};
    r.y    = full[31:0];
    r.cout = full[32];
    r.ovf  = (a_i[31] == bb[31]) && (r.y[31] != a_i[31]);
    r.zero = (r.y == 32'd0);
    return r;
  endfunction

  logic held_valid = 1'b0;
  res_t held;
  res_t e;

  // Scoreboard: push on accept, pop on retire, and check stability across stalls.
  always @(negedge clk) begin
    if (reset) begin
      held_valid = 1'b0;
    end else begin
      if (in_valid && in_ready) q.push_back(model(a, b, cin, sub));
      if (out_valid && held_valid)
        check("stall_hold", 64'({y, cout, ovf, zero}), 64'(held));
      held_valid = out_valid && !out_ready;
      held       = {y, cout, ovf, zero};
      if (out_valid && out_ready) begin
        if (q.size() == 0) begin
          check("unexpected_out", 64'(1), 64'(0));
        end else begin
          e = q.pop_front();
          check("sb_y", 64'(y), 64'(e.y));
          check("sb_flags", 64'({cout, ovf, zero}), 64'({e.cout, e.ovf, e.zero}));
        end
      end
    end
  end

  task automatic send_one(input logic [31:0] a_i, input logic [31:0] b_i,
                          input logic cin_i, input logic sub_i, input string tag);
    int lat;
    out_ready = 1'b1;
    in_valid  = 1'b1;
    a = a_i; b = b_i; cin = cin_i; sub = sub_i;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    check({tag, "_latency"}, 64'(lat), 64'(7));
  endtask

  int n, cyc, seen, lat8;

  initial begin
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    a = '0; b = '0; cin = 1'b0; sub = 1'b0;
    in_valid8 = 1'b0; a8 = '0; b8 = '0; cin8 = 1'b0; sub8 = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", 64'(out_valid), 64'(0));
    check("rst_outputs", 64'({y, cout, ovf, zero}), 64'(0));
    check("rst_in_ready", 64'(in_ready), 64'(0));
    check("rst_out_valid8", 64'(out_valid8), 64'(0));
    reset = 1'b0;
    #1;
    check("post_rst_in_ready", 64'(in_ready), 64'(1));

    send_one(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, "wrap");
    check("wrap_y", 64'(y), 64'(32'h0));
    check("wrap_flags", 64'({cout, ovf, zero}), 64'(3'b101));

    send_one(32'h0000_0005, 32'h0000_0007, 1'b0, 1'b1, "sub");
    check("sub_y", 64'(y), 64'(32'hFFFF_FFFE));
    check("sub_flags", 64'({cout, ovf, zero}), 64'(3'b000));

    send_one(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, "ovf");
    check("ovf_y", 64'(y), 64'(32'h8000_0000));
    check("ovf_flags", 64'({cout, ovf, zero}), 64'(3'b010));

    send_one(32'h0000_0010, 32'h0000_0010, 1'b1, 1'b1, "sub_cin");
    check("sub_cin_y", 64'(y), 64'(32'h0));
    check("sub_cin_flags", 64'({cout, ovf, zero}), 64'(3'b101));

    @(posedge clk); #1;

    // Reset mid-flight
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1;
      a = 32'h100 + 32'(i); b = 32'h3; cin = 1'b0; sub = 1'b0;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    reset = 1'b1;
    q.delete();
    @(posedge clk); #1;
    check("midrst_out_valid", 64'(out_valid), 64'(0));
    check("midrst_in_ready", 64'(in_ready), 64'(0));
    reset = 1'b0;
    #1;
    check("midrst_in_ready_after", 64'(in_ready), 64'(1));
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (out_valid) seen++;
    end
    check("midrst_no_output", 64'(seen), 64'(0));

    // Random stream with backpressure
    n = 0; cyc = 0;
    while (n < 200 && cyc < 5000) begin
      in_valid  = ($urandom_range(0, 9) < 7);
      a         = $urandom;
      b         = $urandom;
      cin       = 1'($urandom_range(0, 1));
      sub       = 1'($urandom_range(0, 1));
      out_ready = 1'($urandom_range(0, 1));
      @(negedge clk);
      if (in_valid && in_ready) n++;
      @(posedge clk); #1;
      cyc++;
    end
    check("stream_accepted", 64'(n), 64'(200));
    in_valid = 1'b0;
    out_ready = 1'b1;
    cyc = 0;
    while (q.size() != 0 && cyc < 100) begin
      @(posedge clk); #1;
      cyc++;
    end
    check("stream_drained", 64'(q.size()), 64'(0));

    // WIDTH=8 instance
    in_valid8 = 1'b1; a8 = 8'hFF; b8 = 8'h01; cin8 = 1'b1; sub8 = 1'b0;
    @(posedge clk); #1;
    in_valid8 = 1'b0;
    lat8 = 1;
    while (!out_valid8 && lat8 < 20) begin
      @(posedge clk); #1;
      lat8++;
    end
    check("w8_latency", 64'(lat8), 64'(5));
    check("w8_y", 64'(y8), 64'(8'h01));
    check("w8_flags", 64'({cout8, ovf8, zero8}), 64'(3'b100));

    repeat (2) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
